// File: rtl/ldtu_mode_orbit_ctrl.sv
// Mode/Orbit controller in front of the LiTe-DTU encoder FSM: delayed Orbit strobes and guarded
// normal<->fallback switchovers. Define ORBIT_CHECK_EN to build the BC0 period watchdog (bc0_err).
module ldtu_mode_orbit_ctrl #(
    parameter int DLY_W     = 8,
    parameter int GUARD     = 4,
    parameter int ORBIT_LEN = 3564,
    parameter int ORBIT_TOL = 2,
    parameter int CNT_W     = 12
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             fb_req,
    input  logic             bc0_in,
    input  logic [DLY_W-1:0] orbit_dly_cfg,
    input  logic [4:0]       enc_state,
    output logic             fallback,
    output logic             Orbit,
    output logic             switch_done,
    output logic             mode_busy,
    output logic [15:0]      orbit_cnt,
    output logic             bc0_err
);

    localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 1);

    typedef enum logic [2:0] {
        N_RUN    = 3'd0,
        N_DRAIN  = 3'd1,
        FB_ENTER = 3'd2,
        FB_RUN   = 3'd3,
        N_ENTER  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [GW-1:0]    guard_q, guard_d;
    logic             done_d;
    logic             pend_q, pend_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             emit;
    logic             hold;
    logic             fallback_q, busy_q, done_q, orbit_q;

    always_comb begin
        state_d = state_q;
        guard_d = '0;
        done_d  = 1'b0;
        case (state_q)
            N_RUN: begin
                if (fb_req) state_d = N_DRAIN;
            end
            N_DRAIN: begin
                // Only leave normal mode outside bc0/header paths and with no Orbit in flight.
                if (!fb_req)                              state_d = N_RUN;
                else if ((enc_state < 5'h0F) && !pend_q)  state_d = FB_ENTER;
            end
            FB_ENTER: begin
                if (guard_q == GUARD_LAST) begin
                    state_d = FB_RUN;
                    done_d  = 1'b1;
                end else begin
                    guard_d = guard_q + 1'b1;
                end
            end
            FB_RUN: begin
                if (!fb_req) state_d = N_ENTER;
            end
            N_ENTER: begin
                if (guard_q == GUARD_LAST) begin
                    state_d = N_RUN;
                    done_d  = 1'b1;
                end else begin
                    guard_d = guard_q + 1'b1;
                end
            end
            default: state_d = N_RUN;
        endcase
    end

    // Orbit is withheld while the next state is a guard state, so it lands on the first RUN cycle.
    assign hold = (state_d == FB_ENTER) || (state_d == N_ENTER);
    assign emit = pend_q && (dly_q == '0) && !hold;

    always_comb begin
        pend_d = pend_q;
        dly_d  = dly_q;
        cnt_d  = cnt_q;
        if (emit) cnt_d = cnt_q + 16'd1;
        if (bc0_in) begin
            pend_d = 1'b1;
            dly_d  = orbit_dly_cfg;
        end else if (emit) begin
            pend_d = 1'b0;
        end else if (pend_q && (dly_q != '0)) begin
            dly_d = dly_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q    <= N_RUN;
            guard_q    <= '0;
            pend_q     <= 1'b0;
            dly_q      <= '0;
            cnt_q      <= '0;
            fallback_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            orbit_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            guard_q    <= guard_d;
            pend_q     <= pend_d;
            dly_q      <= dly_d;
            cnt_q      <= cnt_d;
            fallback_q <= (state_d == FB_ENTER) || (state_d == FB_RUN);
            busy_q     <= (state_d == N_DRAIN) || (state_d == FB_ENTER) || (state_d == N_ENTER);
            done_q     <= done_d;
            orbit_q    <= emit;
        end
    end

    assign fallback    = fallback_q;
    assign mode_busy   = busy_q;
    assign switch_done = done_q;
    assign Orbit       = orbit_q;
    assign orbit_cnt   = cnt_q;

`ifdef ORBIT_CHECK_EN
    localparam logic [CNT_W-1:0] PER_LIMIT = CNT_W'(ORBIT_LEN + ORBIT_TOL);

    logic [CNT_W-1:0] per_q, per_d;
    logic             armed_q;
    logic             err_q;

    always_comb begin
        per_d = per_q;
        if (bc0_in)            per_d = '0;
        else if (per_q != '1)  per_d = per_q + 1'b1;
    end

    // The watchdog stays quiet until the first BC0 after reset has been seen.
    always_ff @(posedge CLK) begin
        if (rst) begin
            per_q   <= '0;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            per_q   <= per_d;
            armed_q <= armed_q | bc0_in;
            err_q   <= err_q | (armed_q && (per_d > PER_LIMIT));
        end
    end

    assign bc0_err = err_q;
`else
    assign bc0_err = 1'b0;
`endif

endmodule

// File: tb/tb_ldtu_mode_orbit_ctrl.sv
// Self-checking bench for ldtu_mode_orbit_ctrl: Orbit strobes are checked against a scoreboard
// of expected (cycle, orbit_cnt) entries; mode sequencing is checked per cycle against tables.
module tb_ldtu_mode_orbit_ctrl;

    localparam int ORBIT_LEN = 3564;
    localparam int ORBIT_TOL = 2;

    logic        CLK = 1'b0;
    logic        rst;
    logic        fb_req;
    logic        bc0_in;
    logic [7:0]  orbit_dly_cfg;
    logic [4:0]  enc_state;
    logic        fallback;
    logic        Orbit;
    logic        switch_done;
    logic        mode_busy;
    logic [15:0] orbit_cnt;
    logic        bc0_err;

    typedef struct {
        int          cycle;
        logic [15:0] cnt;
    } orbit_exp_t;

    orbit_exp_t  expQ[$];
    orbit_exp_t  monE;
    logic [15:0] expCnt = 16'd0;
    bit          monEn = 1'b0;
    int          cyc = 0;
    int          nChecks = 0;
    int          nFail = 0;

    ldtu_mode_orbit_ctrl dut (
        .CLK           (CLK),
        .rst           (rst),
        .fb_req        (fb_req),
        .bc0_in        (bc0_in),
        .orbit_dly_cfg (orbit_dly_cfg),
        .enc_state     (enc_state),
        .fallback      (fallback),
        .Orbit         (Orbit),
        .switch_done   (switch_done),
        .mode_busy     (mode_busy),
        .orbit_cnt     (orbit_cnt),
        .bc0_err       (bc0_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard monitor: every Orbit strobe must match the oldest expectation in cycle and count.
    always @(negedge CLK) begin
        if (monEn) begin
            while (expQ.size() > 0 && expQ[0].cycle < cyc) begin
                monE = expQ.pop_front();
                nChecks++;
                nFail++;
                $display("[TB] FAIL orbit_missed: no Orbit seen at cycle %0d, required Orbit=1 there", monE.cycle);
            end
            if (Orbit === 1'b1) begin
                nChecks++;
                if (expQ.size() == 0) begin
                    nFail++;
                    $display("[TB] FAIL orbit_spurious: Orbit=1 at cycle %0d, required Orbit=0", cyc);
                end else begin
                    monE = expQ.pop_front();
                    if (cyc !== monE.cycle || orbit_cnt !== monE.cnt) begin
                        nFail++;
                        $display("[TB] FAIL orbit_match: got cycle %0d cnt %0d, required cycle %0d cnt %0d",
                                 cyc, orbit_cnt, monE.cycle, monE.cnt);
                    end
                end
            end else if (Orbit !== 1'b0) begin
                nChecks++;
                nFail++;
                $display("[TB] FAIL orbit_level: Orbit=%b at cycle %0d, required 0 or 1", Orbit, cyc);
            end
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic pushOrbit(input int atCycle);
        orbit_exp_t e;
        expCnt   = expCnt + 16'd1;
        e.cycle  = atCycle;
        e.cnt    = expCnt;
        expQ.push_back(e);
    endtask

    task automatic waitOrbits(input int budget);
        int left;
        left = budget;
        while (expQ.size() > 0 && left > 0) begin
            step();
            left--;
        end
        if (expQ.size() > 0) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL orbit_timeout: %0d Orbit strobes outstanding after %0d cycles, required 0",
                     expQ.size(), budget);
            expQ.delete();
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        fb_req        = 1'b1;
        bc0_in        = 1'b1;
        orbit_dly_cfg = 8'd0;
        enc_state     = 5'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            nChecks++;
            if ({fallback, Orbit, switch_done, mode_busy, bc0_err} !== 5'b0 || orbit_cnt !== 16'd0) begin
                nFail++;
                $display("[TB] FAIL reset_outputs: fb=%b orb=%b done=%b busy=%b err=%b cnt=%0d, required all 0",
                         fallback, Orbit, switch_done, mode_busy, bc0_err, orbit_cnt);
            end
        end
        rst    = 1'b0;
        fb_req = 1'b0;
        bc0_in = 1'b0;
        expQ.delete();
        expCnt = 16'd0;
        monEn  = 1'b1;
    endtask

    task automatic test_orbit_latency();
        orbit_dly_cfg = 8'd0;
        bc0_in = 1'b1;
        pushOrbit(cyc + 2);
        step();
        bc0_in = 1'b0;
        waitOrbits(20);
        orbit_dly_cfg = 8'd5;
        bc0_in = 1'b1;
        pushOrbit(cyc + 7);
        step();
        bc0_in = 1'b0;
        waitOrbits(20);
        nChecks++;
        if (orbit_cnt !== 16'd2) begin
            nFail++;
            $display("[TB] FAIL orbit_cnt_two: got %0d, required 2", orbit_cnt);
        end
    endtask

    task automatic test_coincide();
        orbit_dly_cfg = 8'd0;
        bc0_in = 1'b1;
        pushOrbit(cyc + 2);
        step();
        pushOrbit(cyc + 2);
        step();
        bc0_in = 1'b0;
        waitOrbits(20);
    endtask

    task automatic test_back_to_back();
        orbit_dly_cfg = 8'd5;
        bc0_in = 1'b1;
        step();
        bc0_in = 1'b0;
        step();
        bc0_in = 1'b1;
        pushOrbit(cyc + 7);
        step();
        bc0_in = 1'b0;
        waitOrbits(20);
        nChecks++;
        if (orbit_cnt !== expCnt) begin
            nFail++;
            $display("[TB] FAIL back_to_back_cnt: got %0d, required %0d", orbit_cnt, expCnt);
        end
    endtask

    task automatic test_switchover();
        logic [2:0] tab [9] = '{3'b010, 3'b010, 3'b010, 3'b110, 3'b110,
                               3'b110, 3'b110, 3'b101, 3'b100};
        fb_req    = 1'b1;
        enc_state = 5'h14;
        for (int i = 1; i <= 9; i++) begin
            step();
            nChecks++;
            if ({fallback, mode_busy, switch_done} !== tab[i-1]) begin
                nFail++;
                $display("[TB] FAIL switchover_c%0d: fb/busy/done=%b, required %b",
                         i, {fallback, mode_busy, switch_done}, tab[i-1]);
            end
            if (i == 3) enc_state = 5'h06;
        end
    endtask

    task automatic test_orbit_defer();
        logic [2:0] tab [7] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b000, 3'b000};
        int base;
        base   = cyc;
        fb_req = 1'b0;
        orbit_dly_cfg = 8'd0;
        for (int i = 1; i <= 7; i++) begin
            step();
            nChecks++;
            if ({fallback, mode_busy, switch_done} !== tab[i-1]) begin
                nFail++;
                $display("[TB] FAIL defer_c%0d: fb/busy/done=%b, required %b",
                         i, {fallback, mode_busy, switch_done}, tab[i-1]);
            end
            if (i == 1) begin
                bc0_in = 1'b1;
                pushOrbit(base + 5);
            end
            if (i == 2) begin
                bc0_in = 1'b0;
                fb_req = 1'b1;
            end
            if (i == 3) fb_req = 1'b0;
        end
        waitOrbits(10);
    endtask

    task automatic test_drain_pend();
        logic [2:0] tab [18] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010,
                                3'b110, 3'b110, 3'b110, 3'b110, 3'b101,
                                3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b000};
        fb_req        = 1'b1;
        enc_state     = 5'h00;
        orbit_dly_cfg = 8'd5;
        bc0_in        = 1'b1;
        pushOrbit(cyc + 7);
        for (int i = 1; i <= 18; i++) begin
            step();
            bc0_in = 1'b0;
            nChecks++;
            if ({fallback, mode_busy, switch_done} !== tab[i-1]) begin
                nFail++;
                $display("[TB] FAIL drain_pend_c%0d: fb/busy/done=%b, required %b",
                         i, {fallback, mode_busy, switch_done}, tab[i-1]);
            end
            if (i == 9) fb_req = 1'b0;
        end
        waitOrbits(5);
    endtask

    task automatic test_drain_abort();
        logic [2:0] tab [4] = '{3'b010, 3'b010, 3'b000, 3'b000};
        fb_req    = 1'b1;
        enc_state = 5'h1F;
        for (int i = 1; i <= 4; i++) begin
            step();
            nChecks++;
            if ({fallback, mode_busy, switch_done} !== tab[i-1]) begin
                nFail++;
                $display("[TB] FAIL drain_abort_c%0d: fb/busy/done=%b, required %b",
                         i, {fallback, mode_busy, switch_done}, tab[i-1]);
            end
            if (i == 2) fb_req = 1'b0;
        end
        enc_state = 5'h00;
    endtask

    task automatic test_reset_midflight();
        fb_req        = 1'b1;
        enc_state     = 5'h00;
        orbit_dly_cfg = 8'd5;
        bc0_in        = 1'b1;
        step();
        bc0_in = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst    = 1'b0;
        fb_req = 1'b0;
        expCnt = 16'd0;
        nChecks++;
        if ({fallback, Orbit, switch_done, mode_busy, bc0_err} !== 5'b0 || orbit_cnt !== 16'd0) begin
            nFail++;
            $display("[TB] FAIL reset_midflight: fb=%b orb=%b done=%b busy=%b err=%b cnt=%0d, required all 0",
                     fallback, Orbit, switch_done, mode_busy, bc0_err, orbit_cnt);
        end
        repeat (10) step();
        orbit_dly_cfg = 8'd0;
        bc0_in = 1'b1;
        pushOrbit(cyc + 2);
        step();
        bc0_in = 1'b0;
        waitOrbits(10);
        nChecks++;
        if (orbit_cnt !== 16'd1) begin
            nFail++;
            $display("[TB] FAIL cnt_after_reset: got %0d, required 1", orbit_cnt);
        end
    endtask

`ifdef ORBIT_CHECK_EN
    task automatic test_watchdog();
        int base;
        int errCyc;
        rst = 1'b1;
        step();
        rst    = 1'b0;
        expCnt = 16'd0;
        orbit_dly_cfg = 8'd0;
        base   = cyc;
        errCyc = base + 1 + ORBIT_LEN + ORBIT_LEN + ORBIT_TOL + 1;
        bc0_in = 1'b1;
        pushOrbit(cyc + 2);
        for (int i = 1; i <= (errCyc - base) + 5; i++) begin
            step();
            bc0_in = 1'b0;
            if (i == ORBIT_LEN) begin
                bc0_in = 1'b1;
                pushOrbit(cyc + 2);
            end
            if (cyc == base + ORBIT_LEN || cyc == errCyc - 1) begin
                nChecks++;
                if (bc0_err !== 1'b0) begin
                    nFail++;
                    $display("[TB] FAIL watchdog_quiet: bc0_err=%b at cycle %0d, required 0", bc0_err, cyc);
                end
            end
            if (cyc == errCyc || cyc == errCyc + 4) begin
                nChecks++;
                if (bc0_err !== 1'b1) begin
                    nFail++;
                    $display("[TB] FAIL watchdog_err: bc0_err=%b at cycle %0d, required 1", bc0_err, cyc);
                end
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        expCnt = 16'd0;
        nChecks++;
        if (bc0_err !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL watchdog_reset: bc0_err=%b, required 0", bc0_err);
        end
    endtask
`else
    task automatic test_watchdog();
        for (int i = 0; i < 4; i++) begin
            step();
            nChecks++;
            if (bc0_err !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL bc0_err_tied: bc0_err=%b, required 0", bc0_err);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_orbit_latency();
        test_coincide();
        test_back_to_back();
        test_switchover();
        test_orbit_defer();
        test_drain_pend();
        test_drain_abort();
        test_reset_midflight();
        test_watchdog();
        repeat (2) step();
        if (expQ.size() > 0) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL orbit_leftover: %0d expectations unmatched, required 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
